fb_mem_arbiter: RTL and testbench

Shares one single-port synchronous frame-buffer SRAM between two requesters: the VGA scanout fetch (read-only, hard deadline) and the board-game logic (write-only, latency-tolerant). Writes are posted into a small internal FIFO. They drain in memory cycles that scanout does not use. A starvation limit and a vertical-blank priority flip guarantee write progress. The block sits between the VGA timing/pixel pipeline and the SRAM pins on CLK_50.

---
 rtl/fb_mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_fb_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter: shares one single-port synchronous frame-buffer SRAM
// between VGA scanout reads (hard deadline) and posted board-game writes
// (latency tolerant). Writes are queued in a small FIFO. They drain in cycles
// scanout leaves free, when forced by a starvation counter, or during
// vertical blank.

module fb_mem_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 8,
  parameter int WBUF_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          CLK_50,
  input  logic                          RST_N,
  input  logic                          VBLANK,
  input  logic                          RD_REQ,
  input  logic [ADDR_W-1:0]             RD_ADDR,
  output logic                          RD_GNT,
  output logic [DATA_W-1:0]             RD_DATA,
  output logic                          RD_VALID,
  input  logic                          WR_VALID,
  input  logic [ADDR_W-1:0]             WR_ADDR,
  input  logic [DATA_W-1:0]             WR_DATA,
  output logic                          WR_READY,
  output logic [$clog2(WBUF_DEPTH):0]   WBUF_LEVEL,
  output logic                          BUSY,
  output logic                          MEM_CE,
  output logic                          MEM_WE,
  output logic [ADDR_W-1:0]             MEM_ADDR,
  output logic [DATA_W-1:0]             MEM_WDATA,
  input  logic [DATA_W-1:0]             MEM_RDATA
);

  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL   = LVL_W'(WBUF_DEPTH);
  localparam logic [7:0]       STARVE_MAX = 8'(STARVE_LIMIT);

  // Memory cycle chosen for the current clock.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } mem_op_t;

  mem_op_t              mem_op;

  logic [ADDR_W-1:0]    wbuf_addr [WBUF_DEPTH];
  logic [DATA_W-1:0]    wbuf_data [WBUF_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [LVL_W-1:0]     level;
  logic [LVL_W-1:0]     level_next;
  logic [7:0]           starve_cnt;
  logic                 pend;
  logic                 push;
  logic                 pop;
  logic                 mem_rd_q;
  logic                 rd_wait_q;

  // Arbitration: a queued write wins during blanking, when scanout is quiet,
  // or once it has lost STARVE_LIMIT times in a row; otherwise scanout reads.
  always_comb begin
    mem_op = OP_IDLE;
    pend   = (level != '0);
    if (RST_N) begin
      if (pend && (VBLANK || !RD_REQ || (starve_cnt == STARVE_MAX))) begin
        mem_op = OP_WRITE;
      end else if (RD_REQ) begin
        mem_op = OP_READ;
      end
    end
  end

  // Grant, FIFO handshake and next occupancy derived from the decision.
  always_comb begin
    RD_GNT = (mem_op == OP_READ);
    pop    = (mem_op == OP_WRITE);
    push   = WR_VALID && WR_READY;
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + LVL_W'(1);
      2'b01:   level_next = level - LVL_W'(1);
      default: level_next = level;
    endcase
  end

  // Busy while anything is queued or a read has not yet returned its data.
  always_comb begin
    BUSY       = pend || mem_rd_q || rd_wait_q;
    WBUF_LEVEL = level;
  end

  // Write FIFO storage; contents need no reset because the pointers do.
  always_ff @(posedge CLK_50) begin
    if (push) begin
      wbuf_addr[wr_ptr] <= WR_ADDR;
      wbuf_data[wr_ptr] <= WR_DATA;
    end
  end

  // FIFO pointers, occupancy and the registered ready flag.
  always_ff @(posedge CLK_50) begin
    if (!RST_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      WR_READY <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      level    <= level_next;
      WR_READY <= (level_next != FULL_LVL);
    end
  end

  // Starvation counter: counts reads that beat a pending write, saturating.
  always_ff @(posedge CLK_50) begin
    if (!RST_N) begin
      starve_cnt <= '0;
    end else if ((mem_op == OP_WRITE) || !pend) begin
      starve_cnt <= '0;
    end else if ((mem_op == OP_READ) && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  // SRAM command register: one memory cycle per clock, launched at the edge.
  always_ff @(posedge CLK_50) begin
    if (!RST_N) begin
      MEM_CE    <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
    end else begin
      case (mem_op)
        OP_WRITE: begin
          MEM_CE    <= 1'b1;
          MEM_WE    <= 1'b1;
          MEM_ADDR  <= wbuf_addr[rd_ptr];
          MEM_WDATA <= wbuf_data[rd_ptr];
        end
        OP_READ: begin
          MEM_CE    <= 1'b1;
          MEM_WE    <= 1'b0;
          MEM_ADDR  <= RD_ADDR;
        end
        default: begin
          MEM_CE    <= 1'b0;
          MEM_WE    <= 1'b0;
        end
      endcase
    end
  end

  // Read return pipeline: track each read through the SRAM access and the
  // cycle its data appears, then capture it with a one-cycle strobe.
  always_ff @(posedge CLK_50) begin
    if (!RST_N) begin
      mem_rd_q  <= 1'b0;
      rd_wait_q <= 1'b0;
      RD_VALID  <= 1'b0;
      RD_DATA   <= '0;
    end else begin
      mem_rd_q  <= (mem_op == OP_READ);
      rd_wait_q <= mem_rd_q;
      RD_VALID  <= rd_wait_q;
      if (rd_wait_q) begin
        RD_DATA <= MEM_RDATA;
      end
    end
  end

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Directed testbench for fb_mem_arbiter with a read-only SRAM model.

module tb_fb_mem_arbiter;

  logic        CLK_50;
  logic        RST_N;
  logic        VBLANK;
  logic        RD_REQ;
  logic [18:0] RD_ADDR;
  logic        RD_GNT;
  logic [7:0]  RD_DATA;
  logic        RD_VALID;
  logic        WR_VALID;
  logic [18:0] WR_ADDR;
  logic [7:0]  WR_DATA;
  logic        WR_READY;
  logic [2:0]  WBUF_LEVEL;
  logic        BUSY;
  logic        MEM_CE;
  logic        MEM_WE;
  logic [18:0] MEM_ADDR;
  logic [7:0]  MEM_WDATA;
  logic [7:0]  MEM_RDATA;

  logic [7:0]  sram [0:1023];
  int          checks;
  int          passes;

  fb_mem_arbiter #(
    .ADDR_W(19), .DATA_W(8), .WBUF_DEPTH(4), .STARVE_LIMIT(8)
  ) dut (
    .CLK_50(CLK_50), .RST_N(RST_N), .VBLANK(VBLANK),
    .RD_REQ(RD_REQ), .RD_ADDR(RD_ADDR), .RD_GNT(RD_GNT),
    .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
    .WR_VALID(WR_VALID), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .WR_READY(WR_READY), .WBUF_LEVEL(WBUF_LEVEL), .BUSY(BUSY),
    .MEM_CE(MEM_CE), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
  );

  // 50 MHz-style free-running clock.
  initial begin
    CLK_50 = 1'b0;
    forever #5 CLK_50 = ~CLK_50;
  end

  // Synchronous SRAM read port: data one cycle after a read command.
  always @(posedge CLK_50) begin
    if (MEM_CE && !MEM_WE) begin
      MEM_RDATA <= sram[MEM_ADDR[9:0]];
    end
  end

  // Start a new cycle at the falling edge and drive all inputs for it.
  task automatic applyStimulus(input logic rst_n, input logic rd_req,
                               input logic [18:0] rd_addr, input logic wr_valid,
                               input logic [18:0] wr_addr, input logic [7:0] wr_data,
                               input logic vblank);
    @(negedge CLK_50);
    RST_N    = rst_n;
    RD_REQ   = rd_req;
    RD_ADDR  = rd_addr;
    WR_VALID = wr_valid;
    WR_ADDR  = wr_addr;
    WR_DATA  = wr_data;
    VBLANK   = vblank;
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b1, 1'b0, 19'h0, 1'b0, 19'h0, 8'h00, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  initial begin
    checks   = 0;
    passes   = 0;
    RST_N    = 1'b0;
    RD_REQ   = 1'b1;
    RD_ADDR  = '0;
    WR_VALID = 1'b0;
    WR_ADDR  = '0;
    WR_DATA  = '0;
    VBLANK   = 1'b0;
    for (int i = 0; i < 1024; i++) sram[i] = 8'h00;
    sram[16] = 8'hA5;
    for (int i = 0; i < 16; i++) sram[32 + i] = 8'h30 + 8'(i);

    // Reset and idle
    $display("[TB] reset and idle");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 19'h10, 1'b0, 19'h0, 8'h00, 1'b0);
      checkOutput("rst_gnt",    32'(RD_GNT), 0);
      checkOutput("rst_ce",     32'(MEM_CE), 0);
      checkOutput("rst_we",     32'(MEM_WE), 0);
      checkOutput("rst_addr",   32'(MEM_ADDR), 0);
      checkOutput("rst_wdata",  32'(MEM_WDATA), 0);
      checkOutput("rst_valid",  32'(RD_VALID), 0);
      checkOutput("rst_rdata",  32'(RD_DATA), 0);
      checkOutput("rst_wrrdy",  32'(WR_READY), 0);
      checkOutput("rst_level",  32'(WBUF_LEVEL), 0);
      checkOutput("rst_busy",   32'(BUSY), 0);
    end
    idleCycle();
    idleCycle();
    checkOutput("rel_wrrdy", 32'(WR_READY), 1);
    checkOutput("rel_ce",    32'(MEM_CE), 0);
    checkOutput("rel_busy",  32'(BUSY), 0);

    // Read latency
    $display("[TB] read latency");
    applyStimulus(1'b1, 1'b1, 19'h10, 1'b0, 19'h0, 8'h00, 1'b0);
    checkOutput("rd_gnt", 32'(RD_GNT), 1);
    idleCycle();
    checkOutput("rd_t1_ce",    32'(MEM_CE), 1);
    checkOutput("rd_t1_we",    32'(MEM_WE), 0);
    checkOutput("rd_t1_addr",  32'(MEM_ADDR), 32'h10);
    checkOutput("rd_t1_valid", 32'(RD_VALID), 0);
    idleCycle();
    checkOutput("rd_t2_valid", 32'(RD_VALID), 0);
    idleCycle();
    checkOutput("rd_t3_valid", 32'(RD_VALID), 1);
    checkOutput("rd_t3_data",  32'(RD_DATA), 32'hA5);
    idleCycle();
    checkOutput("rd_t4_valid", 32'(RD_VALID), 0);

    // Sixteen back-to-back grants
    for (int i = 0; i < 20; i++) begin
      if (i < 16) begin
        applyStimulus(1'b1, 1'b1, 19'(32 + i), 1'b0, 19'h0, 8'h00, 1'b0);
        checkOutput("burst_gnt", 32'(RD_GNT), 1);
      end else begin
        idleCycle();
      end
      if (i >= 3 && i < 19) begin
        checkOutput("burst_valid", 32'(RD_VALID), 1);
        checkOutput("burst_data",  32'(RD_DATA), 32'(8'h30 + 8'(i - 3)));
      end else if (i == 19) begin
        checkOutput("burst_end", 32'(RD_VALID), 0);
      end
    end

    // FIFO fill under continuous reads: forced write every 9 cycles
    $display("[TB] fifo fill and starvation");
    for (int c = 0; c < 38; c++) begin
      applyStimulus(1'b1, 1'b1, 19'h40, (c < 4), 19'(32'h100 + c),
                    8'(8'h11 * (c + 1)), 1'b0);
      checkOutput("fill_gnt", 32'(RD_GNT),
                  32'(!(c == 9 || c == 18 || c == 27 || c == 36)));
      checkOutput("fill_we", 32'(MEM_CE && MEM_WE),
                  32'(c == 10 || c == 19 || c == 28 || c == 37));
      if (c == 10 || c == 19 || c == 28 || c == 37) begin
        checkOutput("fill_addr",  32'(MEM_ADDR), 32'h100 + (c - 10) / 9);
        checkOutput("fill_wdata", 32'(MEM_WDATA), 32'(8'(8'h11 * ((c - 10) / 9 + 1))));
      end
      if (c == 3)  checkOutput("fill_rdy3",  32'(WR_READY), 1);
      if (c == 4)  checkOutput("fill_rdy4",  32'(WR_READY), 0);
      if (c == 4)  checkOutput("fill_lvl4",  32'(WBUF_LEVEL), 4);
      if (c == 9)  checkOutput("fill_lvl9",  32'(WBUF_LEVEL), 4);
      if (c == 10) checkOutput("fill_rdy10", 32'(WR_READY), 1);
      if (c == 10) checkOutput("fill_lvl10", 32'(WBUF_LEVEL), 3);
      if (c == 37) checkOutput("fill_lvl37", 32'(WBUF_LEVEL), 0);
    end
    for (int i = 0; i < 4; i++) idleCycle();

    // Idle drain of three queued writes
    $display("[TB] idle drain");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 19'h50, 1'b1, 19'(32'h200 + i), 8'(8'hC1 + i), 1'b0);
    end
    idleCycle();
    checkOutput("drain_lvl3", 32'(WBUF_LEVEL), 3);
    checkOutput("drain_busy3", 32'(BUSY), 1);
    for (int i = 0; i < 3; i++) begin
      idleCycle();
      checkOutput("drain_we",    32'(MEM_CE && MEM_WE), 1);
      checkOutput("drain_addr",  32'(MEM_ADDR), 32'h200 + i);
      checkOutput("drain_wdata", 32'(MEM_WDATA), 32'(8'hC1 + i));
      checkOutput("drain_lvl",   32'(WBUF_LEVEL), 32'(2 - i));
      checkOutput("drain_busy",  32'(BUSY), 32'(i < 2));
    end
    idleCycle();
    checkOutput("drain_ce_off", 32'(MEM_CE), 0);

    // VBLANK gives writes priority over pending reads
    $display("[TB] vblank priority");
    applyStimulus(1'b1, 1'b1, 19'h60, 1'b1, 19'h300, 8'hD1, 1'b0);
    applyStimulus(1'b1, 1'b1, 19'h60, 1'b1, 19'h301, 8'hD2, 1'b0);
    applyStimulus(1'b1, 1'b1, 19'h60, 1'b0, 19'h0, 8'h00, 1'b1);
    checkOutput("vb_gnt0", 32'(RD_GNT), 0);
    applyStimulus(1'b1, 1'b1, 19'h60, 1'b0, 19'h0, 8'h00, 1'b1);
    checkOutput("vb_gnt1", 32'(RD_GNT), 0);
    checkOutput("vb_we1",   32'(MEM_CE && MEM_WE), 1);
    checkOutput("vb_addr1", 32'(MEM_ADDR), 32'h300);
    checkOutput("vb_data1", 32'(MEM_WDATA), 32'hD1);
    applyStimulus(1'b1, 1'b1, 19'h60, 1'b0, 19'h0, 8'h00, 1'b1);
    checkOutput("vb_gnt2",  32'(RD_GNT), 1);
    checkOutput("vb_lvl2",  32'(WBUF_LEVEL), 0);
    checkOutput("vb_we2",   32'(MEM_CE && MEM_WE), 1);
    checkOutput("vb_addr2", 32'(MEM_ADDR), 32'h301);
    checkOutput("vb_data2", 32'(MEM_WDATA), 32'hD2);
    idleCycle();
    checkOutput("vb_rd_ce",   32'(MEM_CE), 1);
    checkOutput("vb_rd_we",   32'(MEM_WE), 0);
    checkOutput("vb_rd_addr", 32'(MEM_ADDR), 32'h60);
    for (int i = 0; i < 4; i++) idleCycle();

    // Reset with reads in flight and the FIFO full
    $display("[TB] reset mid-operation");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 19'h70, 1'b1, 19'(32'h400 + i), 8'(8'hE0 + i), 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 19'h70, 1'b0, 19'h0, 8'h00, 1'b0);
    checkOutput("mid_gnt",   32'(RD_GNT), 0);
    checkOutput("mid_full",  32'(WBUF_LEVEL), 4);
    applyStimulus(1'b0, 1'b1, 19'h70, 1'b0, 19'h0, 8'h00, 1'b0);
    checkOutput("mid_valid", 32'(RD_VALID), 0);
    checkOutput("mid_lvl",   32'(WBUF_LEVEL), 0);
    checkOutput("mid_ce",    32'(MEM_CE), 0);
    idleCycle();
    checkOutput("mid_valid2", 32'(RD_VALID), 0);
    for (int i = 0; i < 6; i++) begin
      idleCycle();
      checkOutput("post_ce",    32'(MEM_CE), 0);
      checkOutput("post_valid", 32'(RD_VALID), 0);
      checkOutput("post_lvl",   32'(WBUF_LEVEL), 0);
      if (i == 0) checkOutput("post_wrrdy", 32'(WR_READY), 1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
